comparator_bank: RTL and testbench
==================================

Name: comparator_bank

Overview:
- Synthesisable, clocked, multi-channel successor to the behavioural single-channel comparator emulator.
- Emulates N_CH analog comparator outputs for the test benches and the FPGA test harness.
- Each channel goes high at period start and falls at a programmable trip time.
- Adds a periodic or one-shot run mode, runtime-writable trip times, optional contact-bounce (chatter) emulation at the falling edge, and per-channel fall strobes.

Parameters:
- N_CH, 4: number of comparator channels.
- CH_W, 2: width of the channel index; must satisfy 2^CH_W >= N_CH.
- CNT_W, 16: counter and trip-time width.
- PERIOD, 1000: period length in clk cycles; 2 <= PERIOD <= 2^CNT_W.
- DEFAULT_T_STOP, 10: trip time loaded into every channel at reset.
- GLITCH, 0: number of bounce pulses after each fall; 0 gives a clean edge.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- reset, in, 1: synchronous reset, active-high.
- start, in, 1: level-sampled start request.
- stop, in, 1: level-sampled abort request.
- mode, in, 1: 0 = periodic, 1 = one-shot; sampled when start is accepted.
- wr_en, in, 1: write strobe for a trip time.
- wr_ch, in, CH_W: channel to write.
- wr_data, in, CNT_W: new trip time, in cycles from period start.
- comp, out, N_CH: emulated comparator outputs.
- fall, out, N_CH: one-cycle strobe on the first falling edge of each channel per period.
- period_start, out, 1: one-cycle strobe in the cycle where count = 0.
- busy, out, 1: high while in RUN.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- State after reset:
  - FSM = IDLE, count = 0, mode_q = 0.
  - comp = 0, fall = 0, period_start = 0, busy = 0.
  - Every pending[i] and active[i] = DEFAULT_T_STOP.
- Registers:
  - pending[i] is written by wr_en. A write with wr_ch >= N_CH is ignored.
  - active[i] is the value actually used. It is copied from pending[i] only in the cycle that count becomes 0, so a write during a period takes effect at the next period.
  - A write in the same cycle as the copy is copied (write-then-copy).
- FSM:
  - IDLE:
    - If start=1 and stop=0: next state RUN, count = 0, mode_q = mode, active = pending.
    - Outputs stay 0 in IDLE.
  - RUN:
    - If stop=1: next state IDLE, count = 0. This applies at any count, including mid-chatter.
    - Else if count = PERIOD-1 and mode_q = 1: next state IDLE.
    - Else if count = PERIOD-1 and mode_q = 0: count wraps to 0 and active reloads.
    - Otherwise count increments.
    - start is ignored in RUN.
  - start and stop together: stop wins.
  - reset mid-run returns to the reset state on the next edge.
- Outputs are registered and aligned with count. In a RUN cycle with counter value c, and t = active[i]:
  - comp[i] = 1 when c < t.
  - comp[i] = (c - t) mod 2 when t <= c < t + 2*GLITCH. This gives the sequence 0,1,0,1,... starting with 0 at c = t.
  - comp[i] = 0 otherwise.
  - fall[i] = 1 only when c = t, 1 <= t <= PERIOD-1.
  - period_start = 1 when c = 0.
  - busy = 1 in every RUN cycle.
- Boundaries:
  - t = 0: comp low for the whole period, no fall.
  - t >= PERIOD: comp high for the whole period, no fall.
  - The chatter window is clipped at period end. At wrap, comp returns high in the count = 0 cycle if the new active[i] > 0.
- Latency: first RUN cycle (count = 0, period_start = 1, comp high) is the cycle after the edge that samples start. After stop, the next cycle shows all outputs 0.
- Arithmetic: comparisons are unsigned CNT_W-bit. The chatter bound t + 2*GLITCH is computed with one extra bit so it cannot wrap.

Test Plan:
- Periodic, defaults (PERIOD=1000, t=10, GLITCH=0), start for 1 cycle -> comp[0] high for exactly 10 cycles per period; fall[0] at count 10; period_start every 1000 cycles; busy stays 1.
- Write ch2 = 250 mid-period -> current period keeps fall at 10; next period falls at 250; other channels unchanged. Write with wr_ch = 5 (N_CH = 4) -> no channel changes.
- One-shot mode=1, t = {0, 999, 1000, 500} -> ch0 always 0, no fall; ch1 high through 998, falls at 999; ch2 high all period, no fall; ch3 falls at 500. FSM returns to IDLE after count 999 and all outputs are 0.
- GLITCH=2, t=100 -> comp = 0,1,0,1 at counts 100..103, then 0 from 104 onward; single fall strobe at 100. With t=998, chatter is clipped at 999 and comp is high again at count 0 of the next period.
- start and stop together in IDLE -> stays IDLE. stop at count 101 during chatter -> next cycle comp = 0 and busy = 0. reset at count 500 -> all outputs 0 and trip times back to 10.

Source files
------------

// File: rtl/comparator_bank_if.sv
// Control, trip-time write and comparator output bundle for comparator_bank.
interface comparator_bank_if #(
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             mode;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_data;
    logic [N_CH-1:0]  comp;
    logic [N_CH-1:0]  fall;
    logic             period_start;
    logic             busy;

    modport master (
        output start, stop, mode,
        output wr_en, wr_ch, wr_data,
        input  comp, fall, period_start, busy
    );

    modport slave (
        input  start, stop, mode,
        input  wr_en, wr_ch, wr_data,
        output comp, fall, period_start, busy
    );
endinterface

// File: rtl/comparator_bank.sv
// Multi-channel clocked comparator emulator with programmable trip
// times, periodic/one-shot runs and optional chatter after each fall.
module comparator_bank #(
    parameter int N_CH           = 4,
    parameter int CH_W           = 2,
    parameter int CNT_W          = 16,
    parameter int PERIOD         = 1000,
    parameter int DEFAULT_T_STOP = 10,
    parameter int GLITCH         = 0
) (
    input logic               clk,
    input logic               reset,
    comparator_bank_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] T_RST = CNT_W'(DEFAULT_T_STOP);
    localparam logic [CNT_W:0]   CHAT  = (CNT_W + 1)'(2 * GLITCH);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             mode_q;
    logic             mode_n;
    logic             load;

    logic [CNT_W-1:0] pending   [N_CH];
    logic [CNT_W-1:0] pending_n [N_CH];
    logic [CNT_W-1:0] active    [N_CH];
    logic [CNT_W-1:0] active_n  [N_CH];

    logic [N_CH-1:0]  comp_q;
    logic [N_CH-1:0]  comp_n;
    logic [N_CH-1:0]  fall_q;
    logic [N_CH-1:0]  fall_n;
    logic             ps_q;
    logic             busy_q;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pending_n[i] = pending[i];
            if (bus.wr_en && bus.wr_ch == CH_W'(i))
                pending_n[i] = bus.wr_data;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        mode_n  = mode_q;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_n = RUN;
                    count_n = '0;
                    mode_n  = bus.mode;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    count_n = '0;
                end else if (count == LAST) begin
                    count_n = '0;
                    if (mode_q)
                        state_n = IDLE;
                    else
                        load = 1'b1;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // Outputs are computed from next-cycle values so they line up with count.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            active_n[i] = load ? pending_n[i] : active[i];
            comp_n[i]   = 1'b0;
            fall_n[i]   = 1'b0;
            if (state_n == RUN) begin
                if (count_n < active_n[i]) begin
                    comp_n[i] = 1'b1;
                end else if (active_n[i] != '0 && active_n[i] <= LAST) begin
                    fall_n[i] = (count_n == active_n[i]);
                    if ({1'b0, count_n} < {1'b0, active_n[i]} + CHAT)
                        comp_n[i] = count_n[0] ^ active_n[i][0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            mode_q <= 1'b0;
            comp_q <= '0;
            fall_q <= '0;
            ps_q   <= 1'b0;
            busy_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                pending[i] <= T_RST;
                active[i]  <= T_RST;
            end
        end else begin
            state  <= state_n;
            count  <= count_n;
            mode_q <= mode_n;
            comp_q <= comp_n;
            fall_q <= fall_n;
            ps_q   <= (state_n == RUN) && (count_n == '0);
            busy_q <= (state_n == RUN);
            for (int i = 0; i < N_CH; i++) begin
                pending[i] <= pending_n[i];
                active[i]  <= active_n[i];
            end
        end
    end

    assign bus.comp         = comp_q;
    assign bus.fall         = fall_q;
    assign bus.period_start = ps_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_comparator_bank.sv
// Directed checks of comparator_bank: clean-edge instance and a
// chattering instance with a wider channel index.
module tb_comparator_bank;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    comparator_bank_if #(.N_CH(4), .CH_W(2), .CNT_W(16)) ifa ();
    comparator_bank_if #(.N_CH(4), .CH_W(3), .CNT_W(16)) ifb ();

    comparator_bank #(
        .N_CH(4), .CH_W(2), .CNT_W(16), .PERIOD(1000),
        .DEFAULT_T_STOP(10), .GLITCH(0)
    ) ua (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );

    comparator_bank #(
        .N_CH(4), .CH_W(3), .CNT_W(16), .PERIOD(1000),
        .DEFAULT_T_STOP(10), .GLITCH(2)
    ) ub (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv(input int n);
        while (cyc < n) step();
    endtask

    task automatic wr_a(input int ch, input int d);
        ifa.wr_en = 1'b1;
        ifa.wr_ch = 2'(ch);
        ifa.wr_data = 16'(d);
        step();
        ifa.wr_en = 1'b0;
    endtask

    task automatic wr_b(input int ch, input int d);
        ifb.wr_en = 1'b1;
        ifb.wr_ch = 3'(ch);
        ifb.wr_data = 16'(d);
        step();
        ifb.wr_en = 1'b0;
    endtask

    task automatic start_a(input logic m);
        ifa.start = 1'b1;
        ifa.mode = m;
        step();
        ifa.start = 1'b0;
        ifa.mode = 1'b0;
        cyc = 0;
    endtask

    task automatic start_b(input logic m);
        ifb.start = 1'b1;
        ifb.mode = m;
        step();
        ifb.start = 1'b0;
        ifb.mode = 1'b0;
        cyc = 0;
    endtask

    initial begin
        ifa.start = 0; ifa.stop = 0; ifa.mode = 0;
        ifa.wr_en = 0; ifa.wr_ch = '0; ifa.wr_data = '0;
        ifb.start = 0; ifb.stop = 0; ifb.mode = 0;
        ifb.wr_en = 0; ifb.wr_ch = '0; ifb.wr_data = '0;

        step(); step();
        check("rst_comp", ifa.comp, 4'h0);
        check("rst_fall", ifa.fall, 4'h0);
        check("rst_ps", ifa.period_start, 1'b0);
        check("rst_busy", ifa.busy, 1'b0);
        reset = 1'b0;
        step();
        check("idle_busy", ifa.busy, 1'b0);

        start_a(1'b0);
        check("p0_ps", ifa.period_start, 1'b1);
        check("p0_busy", ifa.busy, 1'b1);
        check("p0_comp", ifa.comp, 4'hF);
        check("p0_fall", ifa.fall, 4'h0);
        adv(9);
        check("c9_comp", ifa.comp, 4'hF);
        check("c9_ps", ifa.period_start, 1'b0);
        adv(10);
        check("c10_comp", ifa.comp, 4'h0);
        check("c10_fall", ifa.fall, 4'hF);
        adv(11);
        check("c11_fall", ifa.fall, 4'h0);
        adv(20);
        wr_a(2, 250);
        adv(249);
        check("c249_comp", ifa.comp, 4'h0);
        adv(999);
        check("c999_ps", ifa.period_start, 1'b0);
        check("c999_busy", ifa.busy, 1'b1);
        adv(1000);
        check("wrap_ps", ifa.period_start, 1'b1);
        check("wrap_comp", ifa.comp, 4'hF);
        adv(1010);
        check("p1_c10_comp", ifa.comp, 4'b0100);
        check("p1_c10_fall", ifa.fall, 4'b1011);
        adv(1249);
        check("p1_c249_comp", ifa.comp, 4'b0100);
        adv(1250);
        check("p1_c250_comp", ifa.comp, 4'h0);
        check("p1_c250_fall", ifa.fall, 4'b0100);

        adv(1260);
        ifa.stop = 1'b1;
        step();
        ifa.stop = 1'b0;
        check("stop_busy", ifa.busy, 1'b0);
        check("stop_comp", ifa.comp, 4'h0);
        check("stop_ps", ifa.period_start, 1'b0);

        ifa.start = 1'b1;
        ifa.stop = 1'b1;
        step();
        check("ss_busy", ifa.busy, 1'b0);
        check("ss_ps", ifa.period_start, 1'b0);
        ifa.start = 1'b0;
        ifa.stop = 1'b0;
        step();
        check("ss_busy2", ifa.busy, 1'b0);

        wr_a(0, 0);
        wr_a(1, 999);
        wr_a(2, 1000);
        wr_a(3, 500);
        start_a(1'b1);
        check("os_c0_comp", ifa.comp, 4'b1110);
        check("os_c0_ps", ifa.period_start, 1'b1);
        adv(498);
        check("os_c498_comp", ifa.comp, 4'b1110);
        adv(500);
        check("os_c500_comp", ifa.comp, 4'b0110);
        check("os_c500_fall", ifa.fall, 4'b1000);
        adv(998);
        check("os_c998_comp", ifa.comp, 4'b0110);
        check("os_c998_fall", ifa.fall, 4'h0);
        adv(999);
        check("os_c999_comp", ifa.comp, 4'b0100);
        check("os_c999_fall", ifa.fall, 4'b0010);
        check("os_c999_busy", ifa.busy, 1'b1);
        adv(1000);
        check("os_end_busy", ifa.busy, 1'b0);
        check("os_end_comp", ifa.comp, 4'h0);
        check("os_end_ps", ifa.period_start, 1'b0);
        adv(1001);
        check("os_end_busy2", ifa.busy, 1'b0);

        start_a(1'b0);
        adv(500);
        check("mr_c500_comp", ifa.comp, 4'b0110);
        reset = 1'b1;
        step();
        check("mr_comp", ifa.comp, 4'h0);
        check("mr_busy", ifa.busy, 1'b0);
        check("mr_fall", ifa.fall, 4'h0);
        reset = 1'b0;
        step();
        start_a(1'b0);
        check("mr_rs_comp", ifa.comp, 4'hF);
        adv(10);
        check("mr_rs_fall", ifa.fall, 4'hF);
        check("mr_rs_comp10", ifa.comp, 4'h0);

        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        wr_b(0, 100);
        wr_b(5, 7);
        start_b(1'b0);
        check("g_c0_comp", ifb.comp, 4'hF);
        check("g_c0_ps", ifb.period_start, 1'b1);
        adv(7);
        check("g_c7_comp", ifb.comp, 4'hF);
        adv(10);
        check("g_c10_comp", ifb.comp, 4'b0001);
        check("g_c10_fall", ifb.fall, 4'b1110);
        adv(11);
        check("g_c11_comp", ifb.comp, 4'b1111);
        check("g_c11_fall", ifb.fall, 4'h0);
        adv(12);
        check("g_c12_comp", ifb.comp, 4'b0001);
        adv(13);
        check("g_c13_comp", ifb.comp, 4'b1111);
        adv(14);
        check("g_c14_comp", ifb.comp, 4'b0001);
        adv(100);
        check("g_c100_comp", ifb.comp, 4'h0);
        check("g_c100_fall", ifb.fall, 4'b0001);
        adv(101);
        check("g_c101_comp", ifb.comp, 4'b0001);
        check("g_c101_fall", ifb.fall, 4'h0);
        adv(102);
        check("g_c102_comp", ifb.comp, 4'h0);
        adv(103);
        check("g_c103_comp", ifb.comp, 4'b0001);
        adv(104);
        check("g_c104_comp", ifb.comp, 4'h0);
        adv(200);
        wr_b(3, 998);
        adv(1000);
        check("g_p1_c0_comp", ifb.comp, 4'hF);
        adv(1998);
        check("g_c998_comp", ifb.comp, 4'h0);
        check("g_c998_fall", ifb.fall, 4'b1000);
        adv(1999);
        check("g_c999_comp", ifb.comp, 4'b1000);
        adv(2000);
        check("g_wrap_comp", ifb.comp, 4'hF);
        check("g_wrap_ps", ifb.period_start, 1'b1);
        adv(2101);
        check("g_c101b_comp", ifb.comp, 4'b1001);
        ifb.stop = 1'b1;
        step();
        ifb.stop = 1'b0;
        check("g_stop_comp", ifb.comp, 4'h0);
        check("g_stop_busy", ifb.busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
